// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the freeze/flush bundle.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic pc_freeze;
        logic if_freeze;
        logic if_flush;
        logic id_freeze;
        logic id_flush;
        logic exe_freeze;
        logic mem_freeze;
    } freeze_bus_t;

    localparam freeze_bus_t FB_NONE = '0;
    localparam freeze_bus_t FB_ALL  = '{pc_freeze: 1'b1, if_freeze: 1'b1, if_flush: 1'b0,
                                        id_freeze: 1'b1, id_flush: 1'b0,
                                        exe_freeze: 1'b1, mem_freeze: 1'b1};

    // Branch beats hazard; flush and freeze never overlap on one register.
    function automatic freeze_bus_t resolve_hazards(input logic branch_taken, input logic hazard);
        freeze_bus_t fb;
        fb = FB_NONE;
        if (branch_taken) begin
            fb.if_flush = 1'b1;
            fb.id_flush = 1'b1;
        end else if (hazard) begin
            fb.pc_freeze = 1'b1;
            fb.if_freeze = 1'b1;
            fb.id_flush  = 1'b1;
        end
        return fb;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stall/flush request and strobe signals between the pipeline stages and the sequencer.
interface pipe_hazard_ctrl_if;
    logic hazard;
    logic branch_taken;
    logic mem_req;
    logic mem_ready;
    logic pc_freeze;
    logic if_freeze;
    logic if_flush;
    logic id_freeze;
    logic id_flush;
    logic exe_freeze;
    logic mem_freeze;

    modport master (
        output hazard, branch_taken, mem_req, mem_ready,
        input  pc_freeze, if_freeze, if_flush, id_freeze, id_flush, exe_freeze, mem_freeze
    );

    modport slave (
        input  hazard, branch_taken, mem_req, mem_ready,
        output pc_freeze, if_freeze, if_flush, id_freeze, id_flush, exe_freeze, mem_freeze
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i)
            q_d = '0;
        else if (inc_i && (q_q != '1))
            q_d = q_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: boot hold, SRAM wait, branch flush and hazard stall arbitration.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus,
    output logic [CNT_W-1:0]  stall_count,
    output logic              mem_timeout
);
    localparam int unsigned BOOT_W = $clog2(BOOT_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t  state_q, state_d;
    freeze_bus_t  fb;
    logic         wait_clr;
    logic [BOOT_W-1:0] boot_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic         timeout_q, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fb       = FB_ALL;
        wait_clr = 1'b0;
        case (state_q)
            BOOT: begin
                if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1))
                    state_d = RUN;
            end
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_d  = MEM_WAIT;
                    wait_clr = 1'b1;
                end else begin
                    fb = resolve_hazards(bus.branch_taken, bus.hazard);
                end
            end
            MEM_WAIT: begin
                // Held branch/hazard resolves in the release cycle itself.
                if (bus.mem_ready) begin
                    fb      = resolve_hazards(bus.branch_taken, bus.hazard);
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    sat_counter #(.W(BOOT_W)) u_boot_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (state_q == BOOT),
        .q_o   (boot_cnt)
    );

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (wait_clr),
        .inc_i (state_q == MEM_WAIT),
        .q_o   (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i ((state_q != BOOT) && fb.pc_freeze),
        .q_o   (stall_count)
    );

    assign timeout_d = timeout_q |
                       ((state_q == MEM_WAIT) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= timeout_d;
    end

    assign mem_timeout    = timeout_q;
    assign bus.pc_freeze  = fb.pc_freeze;
    assign bus.if_freeze  = fb.if_freeze;
    assign bus.if_flush   = fb.if_flush;
    assign bus.id_freeze  = fb.id_freeze;
    assign bus.id_flush   = fb.id_flush;
    assign bus.exe_freeze = fb.exe_freeze;
    assign bus.mem_freeze = fb.mem_freeze;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan sequences then random traffic.
module tb_pipe_hazard_ctrl;
    localparam int BC = 2;
    localparam int MT = 4;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    // Strobe order: {pc_frz, if_frz, if_fl, id_frz, id_fl, exe_frz, mem_frz}
    localparam logic [6:0] E_ALL    = 7'b1101011;
    localparam logic [6:0] E_BRANCH = 7'b0010100;
    localparam logic [6:0] E_HAZARD = 7'b1100100;

    typedef struct packed {
        logic [6:0]    fb;
        logic [CW-1:0] sc;
        logic          to;
    } exp_t;

    logic clk;
    logic rst;
    logic [CW-1:0] stall_count;
    logic mem_timeout;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .BOOT_CYCLES (BC),
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stall_count (stall_count),
        .mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    int   ncycle = 0;

    // Reference model: remaining boot cycles, whether a memory access is outstanding,
    // how long it has been outstanding, and the debug counters.
    int boot_left = BC;
    bit waiting   = 0;
    int wcnt      = 0;
    int m_stall   = 0;
    bit m_to      = 0;

    task automatic cycle(input bit r, input bit hz, input bit br, input bit mq, input bit mr);
        exp_t       e;
        logic [6:0] f;
        bit         booting;
        @(posedge clk);
        #1;
        rst              = r;
        bus.hazard       = hz;
        bus.branch_taken = br;
        bus.mem_req      = mq;
        bus.mem_ready    = mr;
        ncycle++;
        if (r) begin
            f = E_ALL;
            e.sc = '0;
            e.to = 1'b0;
            boot_left = BC; waiting = 0; wcnt = 0; m_stall = 0; m_to = 0;
        end else begin
            e.sc = CW'(m_stall);
            e.to = m_to;
            booting = (boot_left > 0);
            if (booting) begin
                f = E_ALL;
                boot_left--;
            end else if (!waiting && mq && !mr) begin
                f = E_ALL;
                waiting = 1;
                wcnt = 0;
            end else if (waiting && !mr) begin
                f = E_ALL;
                wcnt++;
            end else begin
                if (waiting) begin
                    wcnt++;
                    waiting = 0;
                end
                f = br ? E_BRANCH : (hz ? E_HAZARD : 7'b0);
            end
            if (wcnt >= MT) m_to = 1;
            if (!booting && f[6] && m_stall < SAT) m_stall++;
        end
        e.fb = f;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.fb = {bus.pc_freeze, bus.if_freeze, bus.if_flush, bus.id_freeze,
                        bus.id_flush, bus.exe_freeze, bus.mem_freeze};
                a.sc = stall_count;
                a.to = mem_timeout;
                tests++;
                if (a !== e)
                    begin
                        failed++;
                        $display("FAIL cycle%0d: strobes/stall_count/timeout got %b/%0d/%b want %b/%0d/%b",
                                 ncycle, a.fb, a.sc, a.to, e.fb, e.sc, e.to);
                    end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        bus.hazard = 0; bus.branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        idle(4);
        // hazard alone, then branch+hazard
        cycle(0, 1, 0, 0, 0);
        idle(2);
        cycle(0, 1, 1, 0, 0);
        idle(2);
        // mem_ready 3 cycles after mem_req with branch held throughout
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 1);
        idle(2);
        // mem_ready in RUN without mem_req is ignored
        cycle(0, 0, 0, 0, 1);
        // 10-cycle wait crosses the timeout; hazard held during release
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        idle(2);
        // 20-cycle wait saturates stall_count
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        idle(2);
        // reset mid-wait
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        idle(5);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(199) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(4) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(2) == 0));
        end
        idle(2);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the five-stage ARM core. It generates every freeze and flush strobe consumed by the PC register and the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers. It arbitrates three stall/flush sources: a data hazard from ID, a taken branch from EXE, and a pending SRAM access from MEM. It also holds the pipeline frozen for a fixed boot interval after reset, and keeps a stall-cycle counter and a memory-timeout flag for debug.

## Interface
- BOOT_CYCLES, 2: cycles all freezes stay high after reset release; minimum 1.
- MEM_TIMEOUT, 64: MEM_WAIT cycles after which `mem_timeout` sets.
- CNT_W, 16: width of `stall_count`.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- hazard  in  1  ID stage has a RAW dependency on an in-flight result.
- branch_taken  in  1  EXE stage resolved a taken branch this cycle.
- mem_req  in  1  MEM stage instruction performs an SRAM read or write.
- mem_ready  in  1  SRAM controller completes the access this cycle.
- pc_freeze  out  1  hold the PC register.
- if_freeze  out  1  hold the IF/ID register.
- if_flush  out  1  load NOP into the IF/ID register.
- id_freeze  out  1  hold the ID/EXE register.
- id_flush  out  1  load a bubble into the ID/EXE register.
- exe_freeze  out  1  hold the EXE/MEM register.
- mem_freeze  out  1  hold the MEM/WB register.
- stall_count  out  CNT_W  saturating count of stalled cycles.
- mem_timeout  out  1  sticky; an SRAM wait exceeded MEM_TIMEOUT.

## Operation
- The FSM has three states: BOOT, RUN and MEM_WAIT. Reset forces BOOT.
- BOOT:
  - All five freezes are 1 and both flushes are 0.
  - A boot counter counts up. After BOOT_CYCLES cycles in BOOT, the state moves to RUN.
- RUN outputs are combinational from inputs, in priority order:
  1. `mem_req & ~mem_ready`: all five freezes are 1, flushes are 0. Next state is MEM_WAIT.
  2. `branch_taken`: `if_flush`=1 and `id_flush`=1, all freezes are 0. Any concurrent `hazard` is ignored.
  3. `hazard`: `pc_freeze`=1, `if_freeze`=1, `id_flush`=1. All other outputs are 0.
  4. Otherwise all outputs are 0.
- Flush and freeze are never both asserted on the same register. The stage registers ignore flush while frozen, so this rule guarantees a flush always takes effect.
- MEM_WAIT:
  - While `mem_ready`=0: all freezes are 1 and flushes are 0.
  - On the cycle `mem_ready`=1, the outputs are evaluated exactly as in RUN with rule 1 removed. The next state is RUN. A branch or hazard that was held during the wait therefore resolves in that same cycle.
- Wait counter:
  - Clears on entry to MEM_WAIT and increments each cycle spent in MEM_WAIT.
  - When it equals MEM_TIMEOUT, `mem_timeout` sets and stays set until reset.
  - The FSM keeps waiting regardless; there is no abort.
- stall_count:
  - Increments on every RUN or MEM_WAIT cycle where `pc_freeze`=1.
  - Saturates at all-ones. BOOT cycles are not counted.
- `mem_req` is sampled only in RUN; MEM_WAIT does not re-check it. `mem_ready` in RUN with `mem_req`=0 has no effect.

## Timing
- Reset values, while `rst`=1:
  - State is BOOT and the boot counter is 0.
  - All freezes are 1 and `if_flush`/`id_flush` are 0.
  - `stall_count`=0 and `mem_timeout`=0.
- Freeze and flush outputs have zero latency: they are a same-cycle function of state and inputs, and the stage registers act on them at the next edge.
- The first instruction fetch advances on edge BOOT_CYCLES after reset release.
- An SRAM access that completes in N cycles (mem_ready arriving N-1 cycles after mem_req) freezes the pipeline for N-1 cycles. N=1 means no stall.
- `mem_timeout` rises on the edge that completes MEM_TIMEOUT wait cycles.
- Reset asserted mid-wait or mid-boot returns to BOOT immediately and clears all counters and flags.

## Structure
- A shared core package holds the state encoding (typedef `ctrl_state_t`: BOOT, RUN, MEM_WAIT) and a `freeze_bus_t` struct bundling the five freezes and two flushes.
- One sub-module, `sat_counter`, is natural: a parameterized width with inc/clear/saturate behaviour. It is reused for `stall_count`, the wait counter and the boot counter.

## Test plan
- Reset release with BOOT_CYCLES=2 -> all freezes are 1 for exactly 2 cycles, then 0; `stall_count` stays 0.
- `hazard`=1 for 1 cycle in RUN -> that cycle `pc_freeze`=1, `if_freeze`=1, `id_flush`=1, `exe_freeze`=0; `stall_count` becomes 1.
- `branch_taken`=1 and `hazard`=1 together -> `if_flush`=1, `id_flush`=1, all freezes 0; `stall_count` unchanged.
- `mem_req`=1 with `mem_ready` arriving 3 cycles later while `branch_taken`=1 throughout -> all freezes high for 3 cycles; the release cycle shows `if_flush`=`id_flush`=1 with freezes 0; `stall_count`=3.
- MEM_TIMEOUT=4 with `mem_ready` withheld for 10 cycles -> `mem_timeout` rises after the 4th wait cycle and stays high; freezes stay high until `mem_ready`. Then assert `rst` -> `mem_timeout`=0, `stall_count`=0, state BOOT.
- CNT_W=4 with a 20-cycle memory wait -> `stall_count` saturates at 15.
